// File: rtl/attest_frame_engine_if.sv
// Bus bundle for attest_frame_engine: receive stream, frame buffer port,
// response stream and error status. The engine connects through master.
interface attest_frame_engine_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    logic              frm_valid;
    logic [7:0]        frm_type;
    logic [7:0]        frm_seq;
    logic [15:0]       frm_len;
    logic [ADDR_W-1:0] frm_rd_addr;
    logic [DATA_W-1:0] frm_rd_data;
    logic              frm_release;

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    logic [3:0]        err_code;
    logic [7:0]        err_count;

    modport master (
        input  rx_data, rx_valid, frm_rd_addr, frm_release, tx_ready,
        output rx_ready, frm_valid, frm_type, frm_seq, frm_len, frm_rd_data,
               tx_data, tx_valid, err_code, err_count
    );

    modport slave (
        output rx_data, rx_valid, frm_rd_addr, frm_release, tx_ready,
        input  rx_ready, frm_valid, frm_type, frm_seq, frm_len, frm_rd_data,
               tx_data, tx_valid, err_code, err_count
    );
endinterface

// File: rtl/attest_frame_engine.sv
// Receive-side framing engine for the attestation link: deframes
// header/payload/checksum messages, buffers one frame for the protocol core
// and answers each frame with an ACK or NACK word.
// Optional feature: define ATTEST_FRAME_SEQ_CHECK_EN to enable the header
// sequence-number check (NACK code 2 on mismatch).
module attest_frame_engine #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_WORDS      = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    attest_frame_engine_if.master bus
);
    localparam int unsigned ADDR_W = $clog2(MAX_WORDS);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES);
`ifdef ATTEST_FRAME_SEQ_CHECK_EN
    localparam bit SEQ_CHECK = 1'b1;
`else
    localparam bit SEQ_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PAYLOAD, S_CHK, S_DRAIN, S_HOLD, S_RESP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [MAX_WORDS];
    logic [DATA_W-1:0] csum;
    logic [15:0]       cnt;
    logic [TMO_W-1:0]  idle_cnt;
    logic [3:0]        drain_code;
    logic [7:0]        exp_seq;

    logic              rx_ready;
    logic              frm_valid;
    logic [7:0]        frm_type;
    logic [7:0]        frm_seq;
    logic [15:0]       frm_len;
    logic [DATA_W-1:0] frm_rd_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic [3:0]        err_code;
    logic [7:0]        err_count;

    logic              accept_c;
    logic              in_frame_c;
    logic              timeout_c;
    logic              len_bad_c;
    logic              seq_bad_c;
    logic              nack_fire_c;
    logic [3:0]        nack_code_c;

    assign accept_c   = bus.rx_valid && rx_ready;
    assign in_frame_c = (state == S_PAYLOAD) || (state == S_CHK) || (state == S_DRAIN);
    assign timeout_c  = in_frame_c && !accept_c && (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign len_bad_c  = 17'(bus.rx_data[15:0]) > 17'(MAX_WORDS);
    assign seq_bad_c  = SEQ_CHECK && (bus.rx_data[23:16] != exp_seq);

    function automatic logic [DATA_W-1:0] resp_word(input logic ack, input logic [7:0] seq,
                                                     input logic [3:0] code);
        return DATA_W'({(ack ? 8'hA5 : 8'h5A), seq, 12'h000, code});
    endfunction

    // Detect frame-terminating errors: timeout, bad checksum, end of drain
    always_comb begin
        nack_fire_c = 1'b0;
        nack_code_c = 4'd0;
        if (timeout_c) begin
            nack_fire_c = 1'b1;
            nack_code_c = 4'd4;
        end else if (accept_c && state == S_CHK && bus.rx_data != csum) begin
            nack_fire_c = 1'b1;
            nack_code_c = 4'd3;
        end else if (accept_c && state == S_DRAIN && cnt == frm_len) begin
            nack_fire_c = 1'b1;
            nack_code_c = drain_code;
        end
    end

    // Frame FSM with registered handshake, status and response outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            rx_ready   <= 1'b0;
            frm_valid  <= 1'b0;
            frm_type   <= 8'd0;
            frm_seq    <= 8'd0;
            frm_len    <= 16'd0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            err_code   <= 4'd0;
            err_count  <= 8'd0;
            exp_seq    <= 8'd0;
            csum       <= '0;
            cnt        <= 16'd0;
            idle_cnt   <= '0;
            drain_code <= 4'd0;
        end else if (!enable) begin
            state     <= S_IDLE;
            rx_ready  <= 1'b0;
            frm_valid <= 1'b0;
            tx_valid  <= 1'b0;
            csum      <= '0;
            cnt       <= 16'd0;
            idle_cnt  <= '0;
        end else begin
            idle_cnt <= (accept_c || !in_frame_c) ? '0 : idle_cnt + TMO_W'(1);
            case (state)
                S_IDLE: begin
                    state    <= S_HDR;
                    rx_ready <= 1'b1;
                end
                S_HDR: begin
                    if (accept_c) begin
                        frm_type <= bus.rx_data[31:24];
                        frm_seq  <= bus.rx_data[23:16];
                        frm_len  <= bus.rx_data[15:0];
                        csum     <= bus.rx_data;
                        cnt      <= 16'd0;
                        if (len_bad_c) begin
                            drain_code <= 4'd1;
                            state      <= S_DRAIN;
                        end else if (seq_bad_c) begin
                            drain_code <= 4'd2;
                            state      <= S_DRAIN;
                        end else if (bus.rx_data[15:0] == 16'd0) begin
                            state <= S_CHK;
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (accept_c) begin
                        csum <= csum ^ bus.rx_data;
                        cnt  <= cnt + 16'd1;
                        if (cnt == frm_len - 16'd1) state <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (accept_c && bus.rx_data == csum) begin
                        state     <= S_HOLD;
                        rx_ready  <= 1'b0;
                        frm_valid <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (accept_c) cnt <= cnt + 16'd1;
                end
                S_HOLD: begin
                    if (bus.frm_release) begin
                        state     <= S_RESP;
                        frm_valid <= 1'b0;
                        tx_valid  <= 1'b1;
                        tx_data   <= resp_word(1'b1, frm_seq, 4'd0);
                        err_code  <= 4'd0;
                        exp_seq   <= exp_seq + 8'd1;
                    end
                end
                S_RESP: begin
                    if (bus.tx_ready) begin
                        state    <= S_HDR;
                        tx_valid <= 1'b0;
                        rx_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (nack_fire_c) begin
                state     <= S_RESP;
                rx_ready  <= 1'b0;
                tx_valid  <= 1'b1;
                tx_data   <= resp_word(1'b0, frm_seq, nack_code_c);
                err_code  <= nack_code_c;
                err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
            end
        end
    end

    // Payload buffer write port
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && accept_c) mem[cnt[ADDR_W-1:0]] <= bus.rx_data;
    end

    // Registered payload read, zero beyond the frame length
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) frm_rd_data <= '0;
        else          frm_rd_data <= (16'(bus.frm_rd_addr) < frm_len) ? mem[bus.frm_rd_addr] : '0;
    end

    assign bus.rx_ready    = rx_ready;
    assign bus.frm_valid   = frm_valid;
    assign bus.frm_type    = frm_type;
    assign bus.frm_seq     = frm_seq;
    assign bus.frm_len     = frm_len;
    assign bus.frm_rd_data = frm_rd_data;
    assign bus.tx_data     = tx_data;
    assign bus.tx_valid    = tx_valid;
    assign bus.err_code    = err_code;
    assign bus.err_count   = err_count;
endmodule

// File: tb/tb_attest_frame_engine.sv
// Self-checking bench for attest_frame_engine (MAX_WORDS=16, TIMEOUT_CYCLES=64).
// Responses are predicted into a scoreboard queue and compared on handshake.
module tb_attest_frame_engine;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;

    typedef struct {
        logic [31:0] hdr;
        int          n;
        logic [31:0] w [5];
        bit          auto_chk;
        bit          hold;
        logic [31:0] tx;
        logic [3:0]  code;
        logic [7:0]  cnt;
    } vec_t;

    typedef struct {
        logic [31:0] tx;
        logic [3:0]  code;
        logic [7:0]  cnt;
    } exp_t;

    logic clk;
    logic reset_n;
    logic enable;
    int   n_checks;
    int   n_fail;
    exp_t sb [$];
    vec_t vecs [8];

    attest_frame_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    attest_frame_engine #(.DATA_W(DATA_W), .MAX_WORDS(16), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic vec_t mk(input logic [31:0] hdr, input int n,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input logic [31:0] w4, input bit auto_chk, input bit hold,
                                input logic [31:0] tx, input logic [3:0] code,
                                input logic [7:0] cnt);
        vec_t v;
        v.hdr = hdr; v.n = n;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
        v.auto_chk = auto_chk; v.hold = hold; v.tx = tx; v.code = code; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [31:0] word_of(input vec_t v, input int k);
        return (k < 5) ? v.w[k] : 32'(k);
    endfunction

    // Scoreboard: compare each response at the negedge before its handshake edge
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (reset_n && bus.tx_valid && bus.tx_ready) begin
            if (sb.size() == 0) begin
                bound_fail("unexpected_tx");
            end else begin
                e = sb.pop_front();
                check("tx_data", bus.tx_data, e.tx);
                check("err_code", 32'(bus.err_code), 32'(e.code));
                check("err_count", 32'(bus.err_count), 32'(e.cnt));
            end
        end
    end

    // Present one word and return at the negedge after it is accepted
    task automatic send_word(input logic [31:0] w);
        int t;
        t = 0;
        bus.rx_data  = w;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) bound_fail("rx_ready_wait");
        @(negedge clk);
    endtask

    task automatic wait_resp();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) bound_fail("resp_wait");
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        exp_t        e;
        logic [31:0] x;
        logic [31:0] w;
        int          len;
        v = vecs[i];
        e.tx = v.tx; e.code = v.code; e.cnt = v.cnt;
        sb.push_back(e);
        x = v.hdr;
        send_word(v.hdr);
        for (int k = 0; k < v.n; k++) begin
            w = word_of(v, k);
            if (v.auto_chk && k == v.n - 1) w = x;
            else x = x ^ w;
            send_word(w);
        end
        bus.rx_valid = 1'b0;
        if (v.hold) begin
            len = int'(v.hdr[15:0]);
            check("frm_valid_next", 32'(bus.frm_valid), 32'd1);
            check("frm_type", 32'(bus.frm_type), 32'(v.hdr[31:24]));
            check("frm_seq", 32'(bus.frm_seq), 32'(v.hdr[23:16]));
            check("frm_len", 32'(bus.frm_len), 32'(v.hdr[15:0]));
            if (len > 0) begin
                bus.frm_rd_addr = ADDR_W'(len - 1);
                @(negedge clk);
                check("rd_last", bus.frm_rd_data, word_of(v, len - 1));
                if (len > 2) begin
                    bus.frm_rd_addr = ADDR_W'(2);
                    @(negedge clk);
                    check("rd_addr2", bus.frm_rd_data, word_of(v, 2));
                end
                if (len < 16) begin
                    bus.frm_rd_addr = ADDR_W'(len);
                    @(negedge clk);
                    check("rd_beyond_len", bus.frm_rd_data, 32'd0);
                end
            end
            check("hold_no_tx", 32'(bus.tx_valid), 32'd0);
            bus.frm_release = 1'b1;
            @(negedge clk);
            bus.frm_release = 1'b0;
            check("frm_valid_drop", 32'(bus.frm_valid), 32'd0);
            check("tx_valid_after_release", 32'(bus.tx_valid), 32'd1);
        end else begin
            check("tx_valid_after_err", 32'(bus.tx_valid), 32'd1);
        end
        wait_resp();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        check({tag, "_frm_valid"}, 32'(bus.frm_valid), 32'd0);
        check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
        check({tag, "_tx_data"}, bus.tx_data, 32'd0);
        check({tag, "_frm_hdr"}, {bus.frm_type, bus.frm_seq, bus.frm_len}, 32'd0);
        check({tag, "_rd_data"}, bus.frm_rd_data, 32'd0);
        check({tag, "_err"}, {20'd0, bus.err_count, bus.err_code}, 32'd0);
    endtask

    initial begin
        exp_t e;
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = mk(32'h03000004, 5, 32'd1, 32'd2, 32'd3, 32'd4, 32'h03000000, 0, 1, 32'hA5000000, 4'd0, 8'd0);
        vecs[1] = mk(32'h05010011, 18, 0, 0, 0, 0, 0, 0, 0, 32'h5A010001, 4'd1, 8'd1);
        vecs[2] = mk(32'h03010001, 2, 32'h10, 32'h0, 0, 0, 0, 0, 0, 32'h5A010003, 4'd3, 8'd2);
        vecs[3] = mk(32'h02010002, 3, 32'hDEAD0000, 32'h0000BEEF, 0, 0, 0, 1, 1, 32'hA5010000, 4'd0, 8'd3);
        vecs[4] = mk(32'h04020010, 17, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 1, 1, 32'hA5020000, 4'd0, 8'd3);
        vecs[5] = mk(32'h05090011, 18, 0, 0, 0, 0, 0, 0, 0, 32'h5A090001, 4'd1, 8'd5);
`ifdef ATTEST_FRAME_SEQ_CHECK_EN
        vecs[6] = mk(32'h03070000, 1, 0, 0, 0, 0, 0, 1, 0, 32'h5A070002, 4'd2, 8'd6);
`else
        vecs[6] = mk(32'h03070000, 1, 0, 0, 0, 0, 0, 1, 1, 32'hA5070000, 4'd0, 8'd5);
`endif
        vecs[7] = mk(32'h01000001, 2, 32'hAB, 32'h0, 0, 0, 0, 1, 1, 32'hA5000000, 4'd0, 8'd0);

        reset_n         = 1'b0;
        enable          = 1'b1;
        bus.rx_data     = '0;
        bus.rx_valid    = 1'b0;
        bus.frm_rd_addr = '0;
        bus.frm_release = 1'b0;
        bus.tx_ready    = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) run_vec(i);

        // Timeout after one of two payload words
        e.tx = 32'h5A010004; e.code = 4'd4; e.cnt = 8'd3;
        sb.push_back(e);
        send_word(32'h03010002);
        send_word(32'h00000055);
        bus.rx_valid = 1'b0;
        repeat (63) @(negedge clk);
        check("tmo_not_yet", 32'(bus.tx_valid), 32'd0);
        check("tmo_rx_ready", 32'(bus.rx_ready), 32'd1);
        @(negedge clk);
        check("tmo_tx_valid", 32'(bus.tx_valid), 32'd1);
        wait_resp();

        for (int i = 3; i < 5; i++) run_vec(i);

        // Back-pressure on the response stream
        bus.tx_ready = 1'b0;
        e.tx = 32'h5A030003; e.code = 4'd3; e.cnt = 8'd4;
        sb.push_back(e);
        send_word(32'h03030001);
        send_word(32'h00000010);
        send_word(32'h00000000);
        bus.rx_data  = 32'h03040000;
        for (int c = 0; c < 10; c++) begin
            check("bp_tx_valid", 32'(bus.tx_valid), 32'd1);
            check("bp_tx_data", bus.tx_data, 32'h5A030003);
            check("bp_rx_ready", 32'(bus.rx_ready), 32'd0);
            @(negedge clk);
        end
        bus.tx_ready = 1'b1;
        wait_resp();

        for (int i = 5; i < 7; i++) run_vec(i);

        // Reset pulse in the middle of a payload
        send_word(32'h03030004);
        send_word(32'h00000001);
        send_word(32'h00000002);
        bus.rx_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        run_vec(7);

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/attest_frame_engine.md
# attest_frame_engine

Parametrised receive-side framing engine for the FPGA attestation link. It sits between the external word stream and the attestation protocol core. It deframes header/payload/checksum messages with valid/ready flow control and buffers one frame for the core. It validates length, sequence and checksum, enforces an inter-word timeout, and returns an ACK or NACK word on the transmit stream.

## Interface
- `DATA_W`, 32: link word width; must be ≥ 32. Header, checksum and response fields use bits [31:0]; response upper bits are zero.
- `MAX_WORDS`, 256: payload buffer depth in words; must be a power of two, ≤ 65536.
- `TIMEOUT_CYCLES`, 1024: consecutive idle cycles allowed mid-frame; must be ≥ 2.

Ports:
- `clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: engine enable.
- `rx_data` in DATA_W: received word.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: engine accepts a word.
- `frm_valid` out 1: buffered frame available to the core.
- `frm_type` out 8: type of the buffered frame.
- `frm_seq` out 8: sequence number of the buffered frame.
- `frm_len` out 16: payload length of the buffered frame, in words.
- `frm_rd_addr` in log2(MAX_WORDS): payload read address.
- `frm_rd_data` out DATA_W: registered payload read data.
- `frm_release` in 1: core has consumed the frame.
- `tx_data` out DATA_W: response word.
- `tx_valid` out 1: response valid.
- `tx_ready` in 1: sink accepts the response.
- `err_code` out 4: code of the last NACK; cleared on ACK.
- `err_count` out 8: saturating count of NACKs.

## Operation
- Frame format: header word, then `len` payload words, then checksum word.
  - Header: [31:24] type, [23:16] seq, [15:0] len.
  - Checksum: XOR of the header word and all payload words (full DATA_W).
- States and transitions:
  - IDLE: if `enable`, go to HDR.
  - HDR: on an accepted header:
    - if `len` > MAX_WORDS → DRAIN, code 1;
    - else if seq ≠ expected seq → DRAIN, code 2;
    - else if `len` = 0 → CHK;
    - else → PAYLOAD.
  - PAYLOAD: write each word to buffer[index] and XOR it into the checksum. After word `len`-1 → CHK.
  - CHK: on the accepted word:
    - if it equals the running XOR → HOLD;
    - else → RESP with NACK code 3.
  - DRAIN: discard `len`+1 words, then → RESP with NACK carrying the latched code. If both length and sequence fail, code 1 wins.
  - HOLD: `frm_valid`=1. On `frm_release` → RESP with ACK; expected seq increments (8-bit wrap).
  - RESP: `tx_valid`=1 until `tx_ready`, then → HDR.
- Word acceptance: a word is accepted when `rx_valid` && `rx_ready`.
  - `rx_ready`=1 only in HDR, PAYLOAD, CHK and DRAIN.
  - In HOLD and RESP, `rx_ready`=0 (single frame buffer, back-pressure).
- Response word:
  - [31:24] = 8'hA5 for ACK, 8'h5A for NACK;
  - [23:16] = received header seq;
  - [15:4] = 0;
  - [3:0] = code (0 for ACK).
- NACK side effects: `err_code` ← code; `err_count` increments (saturates at 255). Expected seq is unchanged.
- Timeout: in PAYLOAD, CHK and DRAIN, count consecutive cycles with no accepted word. After TIMEOUT_CYCLES idle cycles → RESP with NACK code 4, with no drain. HDR has no timeout.
- Buffer reads: `frm_rd_data` ← buffer[`frm_rd_addr`] when `frm_rd_addr` < `frm_len`, else 0.
- `enable` low in any state: next cycle go to IDLE and clear `frm_valid`, `tx_valid` and the in-progress frame. Expected seq, `err_code` and `err_count` are kept.

## Timing
- Reset values:
  - `rx_ready`, `frm_valid`, `tx_valid` = 0;
  - `frm_type`, `frm_seq`, `frm_len`, `frm_rd_data`, `tx_data` = 0;
  - `err_code` = 0, `err_count` = 0;
  - expected seq = 0, state = IDLE.
- Reset asserted mid-frame: all of the above apply immediately.
- Checksum accepted at cycle N → `frm_valid` high at N+1.
- `frm_release` sampled at M → `tx_valid` at M+1. `frm_valid` drops at M+1.
- Error detected, or last drain word accepted, at cycle N → `tx_valid` at N+1.
- Timeout: the NACK is registered on the TIMEOUT_CYCLES-th consecutive idle cycle; `tx_valid` follows on the next cycle.
- `tx_data` is stable while `tx_valid` && !`tx_ready`. RESP→HDR on the handshake cycle, so `rx_ready`=1 at the next cycle.
- `frm_rd_data` has 1-cycle latency. It is defined only while `frm_valid`.
- `frm_release` outside HOLD is ignored.

## Configuration
- `ATTEST_FRAME_SEQ_CHECK_EN`:
  - Defined: sequence check active; mismatches produce NACK code 2.
  - Undefined: header seq is ignored, code 2 is never produced, and expected seq still increments on ACK.

## Test plan
Bench parameters: MAX_WORDS=16, TIMEOUT_CYCLES=64, DATA_W=32, macro defined.
- Good frame: header 0x03000004, payload 1,2,3,4, checksum 0x03000000.
  - `frm_valid` with type 3, len 4, seq 0.
  - `frm_rd_addr`=2 → `frm_rd_data`=3 one cycle later.
  - `frm_release` → `tx_data`=0xA5000000; expected seq becomes 1.
- Oversize: header 0x05010011 (len 17) → 18 words drained → `tx_data`=0x5A010001, `err_count`=1, expected seq stays 1.
- Bad checksum: header 0x03010001, payload 0x10, checksum 0 → `tx_data`=0x5A010003, `err_code`=3.
- Timeout: header 0x03010002, one payload word, then 64 idle cycles → `tx_data`=0x5A010004. The next header is accepted normally.
- Sequence mismatch: header 0x03070000 → drain 1 word → 0x5A070002. With the macro undefined, the same frame with a valid checksum is ACKed with 0xA5070000.
- Back-pressure and reset:
  - `tx_ready` held low 10 cycles → `tx_valid` and `tx_data` stable, `rx_ready`=0.
  - `reset_n` pulsed mid-payload → all outputs at reset values; a frame with seq 0 is then accepted.
